time_set_keeper: RTL and testbench

Time-of-day keeper for the clock. It consumes the one-cycle button pulses from the debouncing stage and a 1 Hz tick, and maintains hours, minutes and seconds. It implements the RUN/SET editing state machine for those fields. It sits between the button debouncer and the display/alarm logic and is the sole owner of the current-time registers.

---
 rtl/time_set_keeper_if.sv | 33 +++
 rtl/time_set_keeper.sv | 161 ++++++++++++++++
 tb/tb_time_set_keeper.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/time_set_keeper_if.sv
// ============================================================================
//  Module      : time_set_keeper_if
//  Description : Bundles the button/tick inputs and the time/status outputs
//                of the time-of-day keeper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface time_set_keeper_if;
    logic       tick_1s;
    logic [5:0] btn_nedge;
    logic       btn_pedge;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       set_mode;
    logic [2:0] blink;
    logic       day_pulse;

    // Stimulus side: drives pulses, observes time and status.
    modport master (
        output tick_1s, btn_nedge, btn_pedge,
        input  hour, min, sec, set_mode, blink, day_pulse
    );

    // Keeper side: consumes pulses, owns the time registers.
    modport slave (
        input  tick_1s, btn_nedge, btn_pedge,
        output hour, min, sec, set_mode, blink, day_pulse
    );
endinterface

`default_nettype wire

// File: rtl/time_set_keeper.sv
// ============================================================================
//  Module      : time_set_keeper
//  Description : Time-of-day keeper with RUN/SET editing state machine.
//                Advances hh:mm:ss on a 1 Hz tick in RUN; edits one field
//                at a time (no carry) in SET.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_set_keeper #(
    parameter int HOUR_MAX = 23,
    parameter int MIN_MAX  = 59,
    parameter int SEC_MAX  = 59
) (
    input  wire logic          clk,
    input  wire logic          reset,
    time_set_keeper_if.slave   tk
);

    localparam logic [4:0] c_hour_max = 5'(HOUR_MAX);
    localparam logic [5:0] c_min_max  = 6'(MIN_MAX);
    localparam logic [5:0] c_sec_max  = 6'(SEC_MAX);

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FLD_SEC  = 2'd0,
        FLD_MIN  = 2'd1,
        FLD_HOUR = 2'd2
    } field_t;

    state_t     r_state, w_state_nxt;
    field_t     r_sel,   w_sel_nxt;
    logic [4:0] r_hour,  w_hour_nxt;
    logic [5:0] r_min,   w_min_nxt;
    logic [5:0] r_sec,   w_sec_nxt;
    logic       r_day,   w_day_nxt;
    logic [2:0] w_sel_onehot;

    logic w_set_btn;
    logic w_sel_btn;
    logic w_clr_btn;
    logic w_unused_btn;

    assign w_set_btn    = tk.btn_nedge[0];
    assign w_sel_btn    = tk.btn_nedge[1];
    assign w_clr_btn    = tk.btn_nedge[2];
    // Upper button releases belong to other blocks.
    assign w_unused_btn = ^tk.btn_nedge[5:3];

    // State, field select, time fields and day pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_sel   <= FLD_SEC;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_day   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_hour  <= w_hour_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_day   <= w_day_nxt;
        end
    end

    // Next-state logic: RUN counts with carry, SET edits one field without carry.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_hour_nxt  = r_hour;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_day_nxt   = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_set_btn) begin
                    w_state_nxt = ST_SET;
                    w_sel_nxt   = FLD_SEC;
                end
                // Clearing seconds overrides the tick, so no carry is produced.
                if (w_clr_btn) begin
                    w_sec_nxt = '0;
                end else if (tk.tick_1s) begin
                    if (r_sec == c_sec_max) begin
                        w_sec_nxt = '0;
                        if (r_min == c_min_max) begin
                            w_min_nxt = '0;
                            if (r_hour == c_hour_max) begin
                                w_hour_nxt = '0;
                                w_day_nxt  = 1'b1;
                            end else begin
                                w_hour_nxt = r_hour + 5'd1;
                            end
                        end else begin
                            w_min_nxt = r_min + 6'd1;
                        end
                    end else begin
                        w_sec_nxt = r_sec + 6'd1;
                    end
                end
            end

            ST_SET: begin
                // Leaving SET drops any coincident increment or select.
                if (w_set_btn) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    if (tk.btn_pedge) begin
                        case (r_sel)
                            FLD_SEC:  w_sec_nxt  = (r_sec  == c_sec_max)  ? 6'd0 : r_sec  + 6'd1;
                            FLD_MIN:  w_min_nxt  = (r_min  == c_min_max)  ? 6'd0 : r_min  + 6'd1;
                            FLD_HOUR: w_hour_nxt = (r_hour == c_hour_max) ? 5'd0 : r_hour + 5'd1;
                            default:  ;
                        endcase
                    end
                    if (w_sel_btn) begin
                        case (r_sel)
                            FLD_SEC:  w_sel_nxt = FLD_MIN;
                            FLD_MIN:  w_sel_nxt = FLD_HOUR;
                            default:  w_sel_nxt = FLD_SEC;
                        endcase
                    end
                end
            end

            default: begin
                w_state_nxt = ST_RUN;
                w_sel_nxt   = FLD_SEC;
            end
        endcase
    end

    // One-hot decode of the selected field for the display blink mask.
    always_comb begin
        w_sel_onehot = 3'b000;
        case (r_sel)
            FLD_SEC:  w_sel_onehot = 3'b001;
            FLD_MIN:  w_sel_onehot = 3'b010;
            FLD_HOUR: w_sel_onehot = 3'b100;
            default:  w_sel_onehot = 3'b000;
        endcase
    end

    assign tk.hour      = r_hour;
    assign tk.min       = r_min;
    assign tk.sec       = r_sec;
    assign tk.set_mode  = (r_state == ST_SET);
    assign tk.blink     = (r_state == ST_SET) ? w_sel_onehot : 3'b000;
    assign tk.day_pulse = r_day;

endmodule

`default_nettype wire

// File: tb/tb_time_set_keeper.sv
// ============================================================================
//  Module      : tb_time_set_keeper
//  Description : Self-checking bench for time_set_keeper: a vector table for
//                single-cycle behaviour plus directed multi-cycle sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_set_keeper;

    logic clk;
    logic reset;

    time_set_keeper_if tk_if ();

    time_set_keeper #(
        .HOUR_MAX (23),
        .MIN_MAX  (59),
        .SEC_MAX  (59)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .tk    (tk_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       tick;
        logic [5:0] nedge;
        logic       pedge;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       sm;
        logic [2:0] bl;
        logic       dp;
    } vec_t;

    vec_t vecs [21];

    localparam logic [5:0] c_set = 6'b000001;
    localparam logic [5:0] c_sel = 6'b000010;
    localparam logic [5:0] c_clr = 6'b000100;

    task automatic chk(input string name, input logic [4:0] h, input logic [5:0] m,
                       input logic [5:0] s, input logic sm, input logic [2:0] bl,
                       input logic dp);
        n_tests++;
        if (tk_if.hour !== h || tk_if.min !== m || tk_if.sec !== s ||
            tk_if.set_mode !== sm || tk_if.blink !== bl || tk_if.day_pulse !== dp) begin
            n_fail++;
            $display("FAIL %s: got %0d:%0d:%0d set=%b blink=%b day=%b, expected %0d:%0d:%0d set=%b blink=%b day=%b",
                     name, tk_if.hour, tk_if.min, tk_if.sec, tk_if.set_mode, tk_if.blink,
                     tk_if.day_pulse, h, m, s, sm, bl, dp);
        end
    endtask

    // Apply one cycle of inputs; returns #1 after the sampling edge.
    task automatic step(input logic t, input logic [5:0] n, input logic p);
        @(negedge clk);
        tk_if.tick_1s   = t;
        tk_if.btn_nedge = n;
        tk_if.btn_pedge = p;
        @(posedge clk);
        #1;
        tk_if.tick_1s   = 1'b0;
        tk_if.btn_nedge = 6'd0;
        tk_if.btn_pedge = 1'b0;
    endtask

    task automatic up_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'd0, 1'b1);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset(input string name);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk(name, 5'd0, 6'd0, 6'd0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic day_seen;
        reset           = 1'b1;
        tk_if.tick_1s   = 1'b0;
        tk_if.btn_nedge = 6'd0;
        tk_if.btn_pedge = 1'b0;
        #2;
        chk("reset_state", 5'd0, 6'd0, 6'd0, 1'b0, 3'b000, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        //            tick  nedge      up    h      m      s      sm    blink   dp
        vecs[0]  = '{1'b1, 6'd0,      1'b0, 5'd0, 6'd0, 6'd1, 1'b0, 3'b000, 1'b0};
        vecs[1]  = '{1'b0, c_clr,     1'b0, 5'd0, 6'd0, 6'd0, 1'b0, 3'b000, 1'b0};
        vecs[2]  = '{1'b1, 6'd0,      1'b0, 5'd0, 6'd0, 6'd1, 1'b0, 3'b000, 1'b0};
        vecs[3]  = '{1'b0, c_set,     1'b0, 5'd0, 6'd0, 6'd1, 1'b1, 3'b001, 1'b0};
        vecs[4]  = '{1'b0, 6'd0,      1'b1, 5'd0, 6'd0, 6'd2, 1'b1, 3'b001, 1'b0};
        vecs[5]  = '{1'b1, 6'd0,      1'b1, 5'd0, 6'd0, 6'd3, 1'b1, 3'b001, 1'b0};
        vecs[6]  = '{1'b0, c_sel,     1'b1, 5'd0, 6'd0, 6'd4, 1'b1, 3'b010, 1'b0};
        vecs[7]  = '{1'b0, 6'd0,      1'b1, 5'd0, 6'd1, 6'd4, 1'b1, 3'b010, 1'b0};
        vecs[8]  = '{1'b0, c_sel,     1'b0, 5'd0, 6'd1, 6'd4, 1'b1, 3'b100, 1'b0};
        vecs[9]  = '{1'b0, 6'd0,      1'b1, 5'd1, 6'd1, 6'd4, 1'b1, 3'b100, 1'b0};
        vecs[10] = '{1'b0, c_clr,     1'b0, 5'd1, 6'd1, 6'd4, 1'b1, 3'b100, 1'b0};
        vecs[11] = '{1'b0, c_sel,     1'b0, 5'd1, 6'd1, 6'd4, 1'b1, 3'b001, 1'b0};
        vecs[12] = '{1'b0, 6'b000011, 1'b0, 5'd1, 6'd1, 6'd4, 1'b0, 3'b000, 1'b0};
        vecs[13] = '{1'b1, c_set,     1'b0, 5'd1, 6'd1, 6'd5, 1'b1, 3'b001, 1'b0};
        vecs[14] = '{1'b0, c_set,     1'b1, 5'd1, 6'd1, 6'd5, 1'b0, 3'b000, 1'b0};
        vecs[15] = '{1'b1, c_clr,     1'b0, 5'd1, 6'd1, 6'd0, 1'b0, 3'b000, 1'b0};
        vecs[16] = '{1'b0, 6'd0,      1'b1, 5'd1, 6'd1, 6'd0, 1'b0, 3'b000, 1'b0};
        vecs[17] = '{1'b0, c_sel,     1'b0, 5'd1, 6'd1, 6'd0, 1'b0, 3'b000, 1'b0};
        vecs[18] = '{1'b0, 6'b111000, 1'b0, 5'd1, 6'd1, 6'd0, 1'b0, 3'b000, 1'b0};
        vecs[19] = '{1'b0, c_set,     1'b0, 5'd1, 6'd1, 6'd0, 1'b1, 3'b001, 1'b0};
        vecs[20] = '{1'b0, 6'd0,      1'b1, 5'd1, 6'd1, 6'd1, 1'b1, 3'b001, 1'b0};

        for (int i = 0; i < 21; i++) begin
            step(vecs[i].tick, vecs[i].nedge, vecs[i].pedge);
            chk($sformatf("vec%0d", i), vecs[i].h, vecs[i].m, vecs[i].s,
                vecs[i].sm, vecs[i].bl, vecs[i].dp);
        end

        // 61 ticks from reset: 00:01:01, no day pulse on the way.
        do_reset("reset_before_run");
        day_seen = 1'b0;
        for (int i = 0; i < 61; i++) begin
            step(1'b1, 6'd0, 1'b0);
            if (tk_if.day_pulse !== 1'b0) day_seen = 1'b1;
        end
        chk("run_61_ticks", 5'd0, 6'd1, 6'd1, 1'b0, 3'b000, 1'b0);
        n_tests++;
        if (day_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL run_no_day_pulse: got day_pulse seen=%b, expected 0", day_seen);
        end

        // Field wrap in SET without carry, ticks frozen, exit beats increment.
        do_reset("reset_before_edit");
        step(1'b0, c_set, 1'b0);
        up_n(3);
        chk("set_sec_3", 5'd0, 6'd0, 6'd3, 1'b1, 3'b001, 1'b0);
        step(1'b0, c_sel, 1'b0);
        up_n(59);
        chk("set_min_59", 5'd0, 6'd59, 6'd3, 1'b1, 3'b010, 1'b0);
        up_n(1);
        chk("set_min_wrap", 5'd0, 6'd0, 6'd3, 1'b1, 3'b010, 1'b0);
        step(1'b0, c_sel, 1'b0);
        chk("sel_hour", 5'd0, 6'd0, 6'd3, 1'b1, 3'b100, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 6'd0, 1'b0);
        chk("set_ticks_frozen", 5'd0, 6'd0, 6'd3, 1'b1, 3'b100, 1'b0);
        step(1'b0, c_set, 1'b1);
        chk("exit_beats_up", 5'd0, 6'd0, 6'd3, 1'b0, 3'b000, 1'b0);

        // Day wrap: edit to 23:59:58, then two ticks.
        do_reset("reset_before_day");
        step(1'b0, c_set, 1'b0);
        up_n(58);
        step(1'b0, c_sel, 1'b0);
        up_n(59);
        step(1'b0, c_sel, 1'b0);
        up_n(23);
        step(1'b0, c_set, 1'b0);
        chk("preload_235958", 5'd23, 6'd59, 6'd58, 1'b0, 3'b000, 1'b0);
        step(1'b1, 6'd0, 1'b0);
        chk("tick_235959", 5'd23, 6'd59, 6'd59, 1'b0, 3'b000, 1'b0);
        step(1'b1, 6'd0, 1'b0);
        chk("day_wrap", 5'd0, 6'd0, 6'd0, 1'b0, 3'b000, 1'b1);
        step(1'b0, 6'd0, 1'b0);
        chk("day_pulse_one_cycle", 5'd0, 6'd0, 6'd0, 1'b0, 3'b000, 1'b0);

        // Clear wins over a coincident tick at 10:20:45.
        do_reset("reset_before_clear");
        step(1'b0, c_set, 1'b0);
        up_n(45);
        step(1'b0, c_sel, 1'b0);
        up_n(20);
        step(1'b0, c_sel, 1'b0);
        up_n(10);
        step(1'b0, c_set, 1'b0);
        chk("preload_102045", 5'd10, 6'd20, 6'd45, 1'b0, 3'b000, 1'b0);
        step(1'b1, c_clr, 1'b0);
        chk("clear_beats_tick", 5'd10, 6'd20, 6'd0, 1'b0, 3'b000, 1'b0);

        // Reset mid-edit at 12:34:56 with hour selected.
        do_reset("reset_before_midedit");
        step(1'b0, c_set, 1'b0);
        up_n(56);
        step(1'b0, c_sel, 1'b0);
        up_n(34);
        step(1'b0, c_sel, 1'b0);
        up_n(12);
        chk("preload_123456", 5'd12, 6'd34, 6'd56, 1'b1, 3'b100, 1'b0);
        do_reset("reset_mid_edit");
        step(1'b0, c_set, 1'b0);
        chk("reenter_sel_sec", 5'd0, 6'd0, 6'd0, 1'b1, 3'b001, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
